// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
// Contents: FSM state encoding, mux select values, counter width helper.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

    // Hold counter width: enough to count up to max_hold, never zero bits.
    function automatic int cnt_width(input int max_hold);
        if (max_hold < 1) begin
            return 1;
        end
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mux2.sv
// Two-input N-bit data multiplexer.
// Ports: S select (0 = D0, 1 = D1), D0/D1 data inputs, Y muxed output.
module mux2
    import mux2_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         S,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    output logic [N-1:0] Y
);

    assign Y = (S == SEL_D1) ? D1 : D0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one N-bit resource port between two masters.
// Ports: CLOCK, RESET (async, active high), REQ0/REQ1 requests,
//        D0/D1 requester data, DONE transaction end, GNT0/GNT1 grants,
//        S mux select, Y muxed data, VALID (an owner is driving Y).
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic         DONE,
    output logic         GNT0,
    output logic         GNT1,
    output logic         S,
    output logic [N-1:0] Y,
    output logic         VALID
);

    localparam int CW = cnt_width(MAX_HOLD);

    localparam logic TIMEOUT_EN = (MAX_HOLD != 0);

    // Value at which a contested owner is forced off.
    localparam logic [CW-1:0] CNT_LAST =
        (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

    // Saturation point; the counter never wraps.
    localparam logic [CW-1:0] CNT_SAT =
        (MAX_HOLD == 0) ? '1 : CW'(MAX_HOLD);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          s_q;
    logic          last_q;

    // Per-owner view of the request lines.
    logic   mine;
    logic   other;
    logic   forced;
    logic   rel;
    state_t self_st;
    state_t other_st;

    always_comb begin
        mine     = 1'b0;
        other    = 1'b0;
        self_st  = IDLE;
        other_st = IDLE;
        unique case (state_q)
            OWN0: begin
                mine     = REQ0;
                other    = REQ1;
                self_st  = OWN0;
                other_st = OWN1;
            end
            OWN1: begin
                mine     = REQ1;
                other    = REQ0;
                self_st  = OWN1;
                other_st = OWN0;
            end
            default: begin
                mine     = 1'b0;
                other    = 1'b0;
            end
        endcase
    end

    // DONE, abandon and timeout all collapse into one release event.
    assign forced = TIMEOUT_EN & other & (cnt_q == CNT_LAST);
    assign rel    = DONE | ~mine | forced;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (REQ0 && REQ1) begin
                    // Tie goes to whoever did not own last.
                    state_d = last_q ? OWN0 : OWN1;
                end else if (REQ0) begin
                    state_d = OWN0;
                end else if (REQ1) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (rel) begin
                    cnt_d = '0;
                    if (other) begin
                        state_d = other_st;
                    end else if (mine) begin
                        state_d = self_st;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (other && (cnt_q != CNT_SAT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grants, select and LAST are registered from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            s_q     <= SEL_D0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= (state_d == OWN0);
            gnt1_q  <= (state_d == OWN1);
            if (state_d == OWN0) begin
                s_q    <= SEL_D0;
                last_q <= 1'b0;
            end else if (state_d == OWN1) begin
                s_q    <= SEL_D1;
                last_q <= 1'b1;
            end
        end
    end

    assign GNT0  = gnt0_q;
    assign GNT1  = gnt1_q;
    assign S     = s_q;
    assign VALID = gnt0_q | gnt1_q;

    mux2 #(
        .N (N)
    ) u_mux (
        .S  (s_q),
        .D0 (D0),
        .D1 (D1),
        .Y  (Y)
    );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: vector table plus timing sequences.
// Three instances: default hold, MAX_HOLD=4, MAX_HOLD=0.
module tb_mux2_arbiter;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         req0;
    logic         req1;
    logic         done;
    logic [N-1:0] d0;
    logic [N-1:0] d1;

    logic         g0_a, g1_a, s_a, v_a;
    logic [N-1:0] y_a;
    logic         g0_b, g1_b, s_b, v_b;
    logic [N-1:0] y_b;
    logic         g0_c, g1_c, s_c, v_c;
    logic [N-1:0] y_c;

    int errors = 0;
    int checks = 0;

    mux2_arbiter #(.N(N), .MAX_HOLD(16)) dut (
        .CLOCK(clk), .RESET(rst), .REQ0(req0), .REQ1(req1),
        .D0(d0), .D1(d1), .DONE(done),
        .GNT0(g0_a), .GNT1(g1_a), .S(s_a), .Y(y_a), .VALID(v_a)
    );

    mux2_arbiter #(.N(N), .MAX_HOLD(4)) dut4 (
        .CLOCK(clk), .RESET(rst), .REQ0(req0), .REQ1(req1),
        .D0(d0), .D1(d1), .DONE(done),
        .GNT0(g0_b), .GNT1(g1_b), .S(s_b), .Y(y_b), .VALID(v_b)
    );

    mux2_arbiter #(.N(N), .MAX_HOLD(0)) dut0 (
        .CLOCK(clk), .RESET(rst), .REQ0(req0), .REQ1(req1),
        .D0(d0), .D1(d1), .DONE(done),
        .GNT0(g0_c), .GNT1(g1_c), .S(s_c), .Y(y_c), .VALID(v_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r0;
        logic r1;
        logic dn;
        logic g0;
        logic g1;
        logic s;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        done = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // {GNT0, GNT1, S, VALID, Y} of the default instance
    function automatic logic [63:0] obs_a();
        return {28'd0, g0_a, g1_a, s_a, v_a, y_a};
    endfunction

    function automatic logic [63:0] want(input logic g0, input logic g1,
                                         input logic s);
        logic [N-1:0] y;
        y = s ? d1 : d0;
        return {28'd0, g0, g1, s, g0 | g1, y};
    endfunction

    vec_t vt[16];

    initial begin
        d0   = 32'h80000000;
        d1   = 32'h00000001;
        req0 = 1'b0;
        req1 = 1'b0;
        done = 1'b0;
        rst  = 1'b1;
        #2;
        chk("reset_state", obs_a(), want(1'b0, 1'b0, 1'b0));
        tick();
        rst = 1'b0;

        //       r0    r1    dn    g0    g1    s
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            req0 = vt[i].r0;
            req1 = vt[i].r1;
            done = vt[i].dn;
            tick();
            chk($sformatf("vec%0d", i), obs_a(),
                want(vt[i].g0, vt[i].g1, vt[i].s));
        end

        // Tie right after reset, DONE hand-offs, then async reset in OWN1.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        chk("tie_own0", obs_a(), want(1'b1, 1'b0, 1'b0));
        done = 1'b1;
        tick();
        chk("tie_own1", obs_a(), want(1'b0, 1'b1, 1'b1));
        chk("tie_y1", {32'd0, y_a}, 64'h1);
        tick();
        chk("tie_back0", obs_a(), want(1'b1, 1'b0, 1'b0));
        tick();
        chk("pre_rst_own1", obs_a(), want(1'b0, 1'b1, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", obs_a(), want(1'b0, 1'b0, 1'b0));
        chk("async_rst_y", {32'd0, y_a}, 64'h80000000);
        req0 = 1'b0;
        req1 = 1'b0;
        done = 1'b0;
        tick();
        rst = 1'b0;

        // Single requester latency and release.
        tick();
        chk("single_idle", obs_a(), want(1'b0, 1'b0, 1'b0));
        req0 = 1'b1;
        tick();
        chk("single_k1", obs_a(), want(1'b1, 1'b0, 1'b0));
        tick();
        tick();
        chk("single_k3", obs_a(), want(1'b1, 1'b0, 1'b0));
        done = 1'b1;
        req0 = 1'b0;
        tick();
        chk("single_rel", {63'd0, v_a}, 64'd0);
        done = 1'b0;

        // Contention without DONE: 4-cycle turns vs. no timeout.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic own1;
            tick();
            own1 = ((i / 4) % 2) == 1;
            chk($sformatf("tmo4_c%0d", i), {62'd0, g0_b, g1_b},
                {62'd0, ~own1, own1});
            chk($sformatf("tmo0_c%0d", i), {62'd0, g0_c, g1_c},
                64'd2);
        end

        // Back-to-back transactions keep the grant without a gap.
        do_reset();
        req0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            done = (i % 2) == 1;
            tick();
            chk($sformatf("b2b_c%0d", i), obs_a(),
                want(1'b1, 1'b0, 1'b0));
        end
        req0 = 1'b0;
        done = 1'b0;
        tick();
        chk("b2b_end", obs_a(), want(1'b0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
